// File: rtl/spi_byte_shifter_pkg.sv
// Shared SPI definitions: shifter FSM encoding and default frame length.
package spi_byte_shifter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 slave word shifter driven by pre-synchronized CS/SCLK edge pulses.
// Samples mosi on SCLK rise, advances miso on SCLK fall, MSB first.
module spi_byte_shifter
  import spi_byte_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cs_fall,
  input  logic             cs_rise,
  input  logic             sclk_rise,
  input  logic             sclk_fall,
  input  logic             mosi,
  input  logic [WIDTH-1:0] tx_data,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_load,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] tx_reg, tx_next;
  logic [WIDTH-1:0] rx_reg, rx_next;
  logic [WIDTH-1:0] rx_data_reg, rx_data_next;
  logic             done_reg, done_next;
  logic             rx_valid_reg, rx_valid_next;
  logic             tx_load_reg, tx_load_next;
  logic             miso_reg, miso_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      rx_data_reg  <= '0;
      done_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      tx_load_reg  <= 1'b0;
      miso_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      tx_reg       <= tx_next;
      rx_reg       <= rx_next;
      rx_data_reg  <= rx_data_next;
      done_reg     <= done_next;
      rx_valid_reg <= rx_valid_next;
      tx_load_reg  <= tx_load_next;
      miso_reg     <= miso_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    tx_next       = tx_reg;
    rx_next       = rx_reg;
    rx_data_next  = rx_data_reg;
    done_next     = done_reg;
    rx_valid_next = 1'b0;
    tx_load_next  = 1'b0;

    if (ena) begin
      // Deselect dominates every other pulse arriving in the same cycle.
      if (state_reg == SHIFT && cs_rise) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else if (cs_fall) begin
        state_next   = SHIFT;
        tx_next      = tx_data;
        cnt_next     = '0;
        rx_next      = '0;
        done_next    = 1'b0;
        tx_load_next = 1'b1;
      end else if (state_reg == SHIFT) begin
        if (sclk_rise) begin
          rx_next = {rx_reg[WIDTH-2:0], mosi};
          if (cnt_reg == LAST_BIT) begin
            cnt_next      = '0;
            rx_data_next  = {rx_reg[WIDTH-2:0], mosi};
            rx_valid_next = 1'b1;
            done_next     = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (sclk_fall) begin
          // A fall at bit 0 only reloads once a word has finished; the
          // leading fall of a frame has nothing to advance.
          if (cnt_reg != '0) begin
            tx_next = {tx_reg[WIDTH-2:0], 1'b0};
          end else if (done_reg) begin
            tx_next      = tx_data;
            tx_load_next = 1'b1;
          end
        end
      end
    end

    miso_next = (state_next == SHIFT) ? tx_next[WIDTH-1] : 1'b0;
  end

  assign miso     = miso_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign tx_load  = tx_load_reg;
  assign busy     = (state_reg == SHIFT);

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter: hand-computed vectors, immediate assertions.
module tb_spi_byte_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       cs_fall = 1'b0;
  logic       cs_rise = 1'b0;
  logic       sclk_rise = 1'b0;
  logic       sclk_fall = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_load;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  int         rv_cnt = 0;
  int         tl_cnt = 0;
  logic [7:0] miso_cap = 8'h00;

  always #5 clk = ~clk;

  spi_byte_shifter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi      (mosi),
    .tx_data   (tx_data),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_load   (tx_load),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive pulses, let one posedge consume them, then count output pulses.
  task automatic cycle(input logic cf, input logic cr, input logic sr, input logic sf, input logic m);
    cs_fall = cf; cs_rise = cr; sclk_rise = sr; sclk_fall = sf; mosi = m;
    if (sr) miso_cap = {miso_cap[6:0], miso};
    @(posedge clk);
    #1;
    cs_fall = 1'b0; cs_rise = 1'b0; sclk_rise = 1'b0; sclk_fall = 1'b0; mosi = 1'b0;
    if (rx_valid) rv_cnt++;
    if (tx_load) tl_cnt++;
  endtask

  // n bits of b, MSB first; the fall after the last rise is optional.
  task automatic send_bits(input logic [7:0] b, input int n, input bit final_fall);
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, b[7-k]);
      if (k < n - 1 || final_fall) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic clear_counts();
    rv_cnt = 0;
    tl_cnt = 0;
  endtask

  initial begin
    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_miso", 32'(miso), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_pulses", 32'(rv_cnt + tl_cnt), 32'h0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("step reset_release busy=%0b miso=%0b", busy, miso);

    // Reset mid-frame after 3 bits
    clear_counts();
    tx_data = 8'hA5;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'hFF, 3, 1'b1);
    chk("midrst_busy_before", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_miso", 32'(miso), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rx_data", 32'(rx_data), 32'h0);
    chk("midrst_rx_valid", 32'(rx_valid), 32'h0);
    chk("midrst_tx_load", 32'(tx_load), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_bits(8'hFF, 2, 1'b1);
    chk("midrst_idle_ignored", 32'(busy), 32'h0);
    chk("midrst_no_rx_valid", 32'(rv_cnt), 32'h0);
    clear_counts();
    tx_data = 8'h7E;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h81, 8, 1'b0);
    chk("postrst_rx_data", 32'(rx_data), 32'h81);
    chk("postrst_miso_word", 32'(miso_cap), 32'h7E);
    chk("postrst_rx_valid_cnt", 32'(rv_cnt), 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("step reset_midframe rx_data=%02h miso_word=%02h", rx_data, miso_cap);

    // Single byte: A5 out, 3C in
    clear_counts();
    tx_data = 8'hA5;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_first_miso", 32'(miso), 32'h1);
    chk("single_tx_load_pulse", 32'(tx_load), 32'h1);
    send_bits(8'h3C, 8, 1'b0);
    chk("single_miso_word", 32'(miso_cap), 32'hA5);
    chk("single_rx_data", 32'(rx_data), 32'h3C);
    chk("single_rx_valid_cnt", 32'(rv_cnt), 32'h1);
    chk("single_tx_load_cnt", 32'(tl_cnt), 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_end_busy", 32'(busy), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_rx_valid_is_pulse", 32'(rx_valid), 32'h0);
    $display("step single_byte rx_data=%02h miso_word=%02h", rx_data, miso_cap);

    // Back-to-back words, tx_data changed after the first load
    clear_counts();
    tx_data = 8'hC3;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tx_data = 8'h5A;
    send_bits(8'h96, 8, 1'b1);
    chk("b2b_word1_miso", 32'(miso_cap), 32'hC3);
    chk("b2b_word1_rx", 32'(rx_data), 32'h96);
    chk("b2b_reload_cnt", 32'(tl_cnt), 32'h2);
    chk("b2b_reload_msb", 32'(miso), 32'h0);
    send_bits(8'h69, 8, 1'b0);
    chk("b2b_word2_miso", 32'(miso_cap), 32'h5A);
    chk("b2b_word2_rx", 32'(rx_data), 32'h69);
    chk("b2b_rx_valid_cnt", 32'(rv_cnt), 32'h2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("step back_to_back rx_data=%02h", rx_data);

    // Abort after 5 bits
    clear_counts();
    tx_data = 8'hFF;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h00, 5, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_rx_valid_cnt", 32'(rv_cnt), 32'h0);
    chk("abort_rx_data_held", 32'(rx_data), 32'h69);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_miso", 32'(miso), 32'h0);
    $display("step abort rx_data=%02h busy=%0b", rx_data, busy);

    // cs_rise coincides with the 8th sclk_rise
    clear_counts();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h00, 7, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("coll_cs_rx_valid_cnt", 32'(rv_cnt), 32'h0);
    chk("coll_cs_rx_data", 32'(rx_data), 32'h69);
    chk("coll_cs_busy", 32'(busy), 32'h0);

    // sclk_rise and sclk_fall together: only the receive side moves
    clear_counts();
    tx_data = 8'hA5;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("coll_sclk_miso_held", 32'(miso), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, (k < 4) ? 1'b1 : 1'b0);
      if (k < 7) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("coll_sclk_miso_word", 32'(miso_cap), 32'hA5);
    chk("coll_sclk_rx_data", 32'(rx_data), 32'hF0);
    chk("coll_sclk_rx_valid_cnt", 32'(rv_cnt), 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("step collisions rx_data=%02h miso_word=%02h", rx_data, miso_cap);

    // Enable low during 3 sclk pulses
    clear_counts();
    tx_data = 8'h3C;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ena = 1'b0;
    send_bits(8'hFF, 3, 1'b1);
    chk("ena_miso_frozen", 32'(miso), 32'h0);
    chk("ena_busy_frozen", 32'(busy), 32'h1);
    chk("ena_no_rx_valid", 32'(rv_cnt), 32'h0);
    ena = 1'b1;
    send_bits(8'hC5, 8, 1'b0);
    chk("ena_miso_word", 32'(miso_cap), 32'h3C);
    chk("ena_rx_data", 32'(rx_data), 32'hC5);
    chk("ena_rx_valid_cnt", 32'(rv_cnt), 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("step enable rx_data=%02h miso_word=%02h", rx_data, miso_cap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_byte_shifter.md
SPI_BYTE_SHIFTER -- requirements
Module: spi_byte_shifter

Interface
REQ-001 Parameter: WIDTH, 8, frame length in bits (legal 2..32).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: ena  input  1  global enable; when 0, all edge inputs ignored and state held.
REQ-005 Port: cs_fall  input  1  one-cycle pulse, chip-select asserted (from upstream edge detector).
REQ-006 Port: cs_rise  input  1  one-cycle pulse, chip-select deasserted.
REQ-007 Port: sclk_rise  input  1  one-cycle pulse, synchronized SCLK rising edge.
REQ-008 Port: sclk_fall  input  1  one-cycle pulse, synchronized SCLK falling edge.
REQ-009 Port: mosi  input  1  synchronized serial data in.
REQ-010 Port: tx_data  input  WIDTH  parallel word to transmit.
REQ-011 Port: miso  output  1  serial data out, MSB first.
REQ-012 Port: rx_data  output  WIDTH  last complete received word.
REQ-013 Port: rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-014 Port: tx_load  output  1  one-cycle pulse, tx_data captured into shifter.
REQ-015 Port: busy  output  1  high while in SHIFT state.

Function
REQ-016 Protocol SHALL be SPI mode 0: sample mosi on sclk_rise, advance miso on sclk_fall, MSB first.
REQ-017 FSM SHALL have states IDLE and SHIFT; reset state IDLE.
REQ-018 IDLE -> SHIFT on cs_fall with ena=1; same cycle: tx shifter <= tx_data, bit counter <= 0, rx shifter <= 0, tx_load pulses next cycle.
REQ-019 SHIFT -> IDLE on cs_rise with ena=1; partial word discarded, no rx_valid, bit counter <= 0.
REQ-020 In SHIFT, sclk_rise SHALL shift mosi into rx shifter LSB and increment bit counter (width ceil(log2(WIDTH))).
REQ-021 On sclk_rise with bit counter = WIDTH-1: rx_data <= {rx shifter[WIDTH-2:0], mosi}, rx_valid=1 next cycle, bit counter wraps to 0.
REQ-022 In SHIFT, sclk_fall with bit counter != 0 SHALL shift tx shifter left by one; with bit counter = 0 and at least one word completed in this frame, SHALL reload tx shifter from tx_data and pulse tx_load.
REQ-023 sclk_fall with bit counter = 0 before any sclk_rise in the frame SHALL be ignored.
REQ-024 miso SHALL equal tx shifter MSB in SHIFT, 0 in IDLE (registered, zero combinational path from inputs).
REQ-025 Simultaneous cs_rise and any sclk pulse: cs_rise wins, sclk pulse discarded.
REQ-026 Simultaneous sclk_rise and sclk_fall: sclk_rise processed, sclk_fall discarded.
REQ-027 cs_fall while in SHIFT SHALL restart the frame as in REQ-018.
REQ-028 sclk pulses in IDLE SHALL be ignored.
REQ-029 rx_data SHALL hold its value until the next completed word; rx_valid and tx_load never high longer than one cycle.
REQ-030 ena=0 SHALL freeze all registers; pulses arriving while ena=0 are lost, not queued.

Reset
REQ-031 rst=1 SHALL asynchronously force: state IDLE, bit counter 0, rx/tx shifters 0, rx_data 0, miso 0, rx_valid 0, tx_load 0, busy 0.
REQ-032 rst asserted mid-frame SHALL abort the frame with no rx_valid; operation resumes only on a new cs_fall after rst deasserts.

Structure
REQ-033 FSM state encoding and the default WIDTH constant SHALL live in the shared SPI package; no other typedefs needed.
REQ-034 Block SHALL be a single module with no sub-modules; edge detection and synchronization remain upstream.

Verification
REQ-035 Reset: rst pulse mid-frame after 3 bits -> all outputs 0, no rx_valid, next frame received correctly.
REQ-036 Single byte: tx_data=0xA5, cs_fall, 8 clocks with mosi bits of 0x3C -> miso sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid; one tx_load.
REQ-037 Back-to-back: two words in one frame, tx_data changed to 0x5A after first tx_load -> second word on miso = 0x5A, two rx_valid pulses.
REQ-038 Abort: cs_rise after 5 sclk_rise -> no rx_valid, rx_data unchanged, busy=0, miso=0.
REQ-039 Collision: cs_rise same cycle as 8th sclk_rise -> no rx_valid; sclk_rise+sclk_fall same cycle -> only rx shifts.
REQ-040 Enable: ena=0 during 3 sclk_rise pulses -> counter and shifters unchanged; frame completes after 8 enabled pulses.
